// File: rtl/chunked_ripple_adder.sv
// -----------------------------------------------------------------------------
// chunked_ripple_adder
//
// Multi-cycle ripple-carry adder/subtractor. A WIDTH-bit operand pair is
// accepted through a valid/ready handshake, then added CHUNK bits per clock,
// least-significant chunk first. The carry between chunks lives in a register,
// so the combinational path is a single CHUNK-bit adder regardless of WIDTH.
// The finished result is presented through a second valid/ready handshake.
//
// Subtraction is a - b - cin, computed as a + ~b + ~cin. With this form,
// cout=1 means "no borrow".
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand set valid
//   in_ready   block idle and able to accept operands
//   a, b       WIDTH-bit operands
//   cin        carry-in (borrow-in when sub=1)
//   sub        0: a+b+cin   1: a-b-cin
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       carry out of the MSB
//   overflow   signed two's-complement overflow
// -----------------------------------------------------------------------------

// One CHUNK-bit slice of the ripple adder: {c_o, s_o} = a_i + b_i + c_i.
module chunked_ripple_adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);
    logic [CHUNK:0] res;

    assign res = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    assign s_o = res[CHUNK-1:0];
    assign c_o = res[CHUNK];
endmodule

module chunked_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    // Reject chunkings that would leave a partial top chunk.
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_ripple_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;      // b already conditioned for subtract
    logic [WIDTH-1:0] acc_q,   acc_d;    // partial result, filled chunk by chunk
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             carry_q, carry_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;
    logic [KW-1:0]    k_q,     k_d;

    logic [31:0]      base;              // bit offset of chunk k
    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_chunk;

    assign base    = 32'(k_q) * 32'(CHUNK);
    assign a_chunk = a_q[base +: CHUNK];
    assign b_chunk = b_q[base +: CHUNK];

    chunked_ripple_adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i (a_chunk),
        .b_i (b_chunk),
        .c_i (carry_q),
        .s_o (s_chunk),
        .c_o (c_chunk)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as a + ~b + ~cin so the chunk adder never changes.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                acc_d[base +: CHUNK] = s_chunk;
                carry_d              = c_chunk;
                if (k_q == K_LAST) begin
                    // Results are published only here, so partial chunks
                    // never reach the outputs.
                    state_d = DONE;
                    sum_d   = acc_d;
                    cout_d  = c_chunk;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_chunked_ripple_adder.sv
// -----------------------------------------------------------------------------
// Testbench for chunked_ripple_adder. Three instances run side by side with
// CHUNK = 4, 1 and 16 (WIDTH = 16). Each has its own stimulus process, which
// pushes expected results into a queue when it issues an operation, and its
// own monitor, which compares every cycle that out_valid is high and pops
// when the result is handshaken.
// -----------------------------------------------------------------------------
module tb_chunked_ripple_adder;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;   // edge number on which the operands are accepted
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input int ch, input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL CH=%0d %s: got 0x%0h, want 0x%0h (t=%0t)", ch, nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int sa, sb, ua, ub, ci, sr, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        ci = int'(cin);
        if (sub) begin
            sr     = sa - sb - ci;
            ur     = ua - ub - ci;
            e.cout = (ur >= 0);
        end else begin
            sr     = sa + sb + ci;
            ur     = ua + ub + ci;
            e.cout = (ur > 65535);
        end
        e.sum = W'(ur);
        e.ovf = (sr > 32767) || (sr < -32768);
        e.acc = 0;
        return e;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int CH   = (gi == 0) ? 4 : (gi == 1) ? 1 : 16;
        localparam int N    = W / CH;
        localparam int ABRT = (N >= 3) ? 3 : N;   // reset edge offset after accept

        logic         rst_n, in_valid, in_ready, cin, sub;
        logic         out_valid, out_ready, cout, overflow;
        logic [W-1:0] a, b, sum;
        logic         done = 1'b0;
        bit           bp_rnd = 1'b0;
        bit           first = 1'b0;
        exp_t         q[$];

        chunked_ripple_adder #(
            .WIDTH (W),
            .CHUNK (CH)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .overflow  (overflow)
        );

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic scramble();
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
        endtask

        task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic icin, input logic isub);
            exp_t e;
            int   t;
            a = ia; b = ib; cin = icin; sub = isub;
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 300) begin
                step();
                t++;
                if (bp_rnd) out_ready = ($urandom_range(0, 2) != 0);
            end
            if (in_ready) begin
                e     = model(ia, ib, icin, isub);
                e.acc = cyc + 1;
                q.push_back(e);
                step();
                check(CH, "in_ready_after_accept", in_ready, 0);
            end else begin
                check(CH, "accept_timeout", in_ready, 1);
            end
            in_valid = 1'b0;
            scramble();   // operands are don't-care while the op runs
        endtask

        task automatic drain();
            int t;
            t = 0;
            out_ready = 1'b1;
            while (q.size() != 0 && t < 400) begin
                step();
                t++;
            end
            check(CH, "drain_outstanding", q.size(), 0);
            step();
            step();
        endtask

        always @(negedge clk) begin
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    check(CH, "spurious_out_valid", out_valid, 0);
                end else begin
                    check(CH, "sum", sum, q[0].sum);
                    check(CH, "cout", cout, q[0].cout);
                    check(CH, "overflow", overflow, q[0].ovf);
                    check(CH, "in_ready_in_done", in_ready, 0);
                    if (!first) begin
                        check(CH, "latency", cyc - q[0].acc, N);
                        first = 1'b1;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        first = 1'b0;
                    end
                end
            end
        end

        initial begin
            int t;
            rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            repeat (2) step();
            rst_n = 1'b1;
            check(CH, "rst_out_valid", out_valid, 0);
            check(CH, "rst_sum", sum, 0);
            check(CH, "rst_cout", cout, 0);
            check(CH, "rst_overflow", overflow, 0);
            check(CH, "rst_in_ready", in_ready, 1);

            // Directed corner cases.
            issue(16'h0001, 16'h0000, 1'b0, 1'b0);
            issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
            issue(16'h000B, 16'h0006, 1'b1, 1'b0);
            issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
            issue(16'h8000, 16'h8000, 1'b0, 1'b0);
            issue(16'h0005, 16'h0003, 1'b0, 1'b1);
            issue(16'h0003, 16'h0005, 1'b0, 1'b1);
            issue(16'h0005, 16'h0003, 1'b1, 1'b1);
            issue(16'h8000, 16'h0001, 1'b0, 1'b1);
            issue(16'h0000, 16'h8000, 1'b0, 1'b1);
            drain();

            // Backpressure: result held, new operands ignored.
            out_ready = 1'b0;
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            t = 0;
            while (!out_valid && t < 100) begin
                step();
                t++;
            end
            check(CH, "bp_out_valid", out_valid, 1);
            for (int i = 0; i < 6; i++) begin
                in_valid = ~in_valid;
                scramble();
                step();
                check(CH, "bp_in_ready", in_ready, 0);
                check(CH, "bp_hold_valid", out_valid, 1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
            check(CH, "bp_release_valid", out_valid, 0);
            check(CH, "bp_release_ready", in_ready, 1);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            drain();

            // Abort mid-RUN with reset: no output, outputs cleared.
            issue(16'h1234, 16'h4321, 1'b1, 1'b0);
            drain();
            check(CH, "abort_pre_idle", in_ready, 1);
            a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            repeat (ABRT - 1) step();
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            check(CH, "abort_out_valid", out_valid, 0);
            check(CH, "abort_sum", sum, 0);
            check(CH, "abort_cout", cout, 0);
            check(CH, "abort_overflow", overflow, 0);
            check(CH, "abort_in_ready", in_ready, 1);
            repeat (N + 3) step();
            issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
            drain();

            // Random operations with random output backpressure and idle gaps.
            bp_rnd = 1'b1;
            for (int i = 0; i < 25; i++) begin
                issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 2)) step();
            end
            bp_rnd = 1'b0;
            drain();
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g[0].done && g[1].done && g[2].done) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60000) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", t);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
